// File: rtl/basilisk_result_arbiter.sv
// Round-robin merge of FPU pipeline results into one writeback stream.
// Accepted results sit in a 2-entry skid FIFO so in_ready ignores out_ready.
package basilisk_pkg;

   typedef struct packed {
      logic [63:0] value;
      logic [4:0]  fflags;
   } fpu_result_t;

   typedef struct packed {
      logic [4:0]  dest_reg_addr;
      fpu_result_t result;
   } basilisk_result_t;

endpackage

module basilisk_result_arbiter
   import basilisk_pkg::*;
#(
   parameter  int NUM_PORTS = 5,
   localparam int PW        = $clog2(NUM_PORTS)
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic             [NUM_PORTS-1:0]   in_valid,
   output logic             [NUM_PORTS-1:0]   in_ready,
   input  basilisk_result_t [NUM_PORTS-1:0]   in_data,
   output logic                               out_valid,
   input  logic                               out_ready,
   output basilisk_result_t                   out_data,
   output logic             [PW-1:0]          out_port,
   output logic             [1:0]             occupancy
);

   logic [PW-1:0]    last;
   logic [PW-1:0]    winner;
   logic [PW-1:0]    cand;
   logic             found;
   logic             space;
   logic             push;
   logic             pop;

   basilisk_result_t mem_data [2];
   logic [PW-1:0]    mem_port [2];
   logic             head;
   logic             tail;
   logic [1:0]       count;

   // Search for the first valid port starting just after the last grant.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         cand = PW'((int'(last) + k) % NUM_PORTS);
         if (!found && in_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   // Offer the winner a slot only when the registered count shows room.
   always_comb begin
      space    = (count != 2'd2);
      push     = rst && found && space;
      pop      = (count != 2'd0) && out_ready;
      in_ready = '0;
      if (push) begin
         in_ready[winner] = 1'b1;
      end
   end

   // Skid FIFO storage, pointers, count and the round-robin pointer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count       <= 2'd0;
         head        <= 1'b0;
         tail        <= 1'b0;
         last        <= PW'(NUM_PORTS - 1);
         mem_data[0] <= '0;
         mem_data[1] <= '0;
         mem_port[0] <= '0;
         mem_port[1] <= '0;
      end else begin
         if (push) begin
            mem_data[tail] <= in_data[winner];
            mem_port[tail] <= winner;
            tail           <= ~tail;
            last           <= winner;
         end
         if (pop) begin
            head <= ~head;
         end
         unique case (1'b1)
            (push && !pop): count <= count + 2'd1;
            (!push && pop): count <= count - 2'd1;
            default:        count <= count;
         endcase
      end
   end

   // Head entry drives the output straight from registers.
   always_comb begin
      out_valid = (count != 2'd0);
      out_data  = mem_data[head];
      out_port  = mem_port[head];
      occupancy = count;
   end

endmodule
